muldiv_controller: RTL and testbench

- Sequencer for the shared multiplier and divider units and the HI/LO register pair.
- Sits between the control unit and the mult/div datapath. Accepts mult/div/mfhi/mflo requests and issues single-cycle start pulses.
- Waits on ready, commits HI/LO write enables, and raises stall, div-by-zero and timeout indications back to the control unit.
- Ensures exactly one HI/LO writer per operation and no read of HI/LO while an operation is in flight.

---
 rtl/muldiv_controller.sv | 135 +++++++++++++
 tb/tb_muldiv_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_controller.sv
// ============================================================================
// muldiv_controller : sequences the shared multiplier/divider and HI/LO writes
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module muldiv_controller #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_mult_i,
  input  logic req_div_i,
  input  logic req_mfhi_i,
  input  logic req_mflo_i,
  input  logic mult_ready_i,
  input  logic div_ready_i,
  input  logic div_zero_i,
  output logic mult_start_o,
  output logic div_start_o,
  output logic hi_wr_o,
  output logic lo_wr_o,
  output logic hilo_src_o,
  output logic busy_o,
  output logic stall_o,
  output logic done_o,
  output logic div_zero_exc_o,
  output logic timeout_exc_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START_M = 3'd1,
    S_WAIT_M  = 3'd2,
    S_START_D = 3'd3,
    S_WAIT_D  = 3'd4,
    S_COMMIT  = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src_q, src_d;
  logic             zcause_q, zcause_d;
  logic             w_any_req;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      src_q    <= 1'b0;
      zcause_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      zcause_q <= zcause_d;
    end
  end

  // hilo_src and the counter are set on entry to START so both are valid there.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    zcause_d = zcause_q;
    case (state_q)
      S_IDLE: begin
        if (req_mult_i) begin
          state_d = S_START_M;
          src_d   = 1'b0;
          cnt_d   = '0;
        end else if (req_div_i) begin
          state_d = S_START_D;
          src_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      S_START_M: begin
        cnt_d   = '0;
        state_d = S_WAIT_M;
      end
      S_WAIT_M: begin
        if (mult_ready_i) begin
          state_d = S_COMMIT;
        end else if (cnt_q == c_cnt_last) begin
          state_d  = S_ERR;
          zcause_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_START_D: begin
        cnt_d   = '0;
        state_d = S_WAIT_D;
      end
      S_WAIT_D: begin
        if (div_zero_i) begin
          state_d  = S_ERR;
          zcause_d = 1'b1;
        end else if (div_ready_i) begin
          state_d = S_COMMIT;
        end else if (cnt_q == c_cnt_last) begin
          state_d  = S_ERR;
          zcause_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign mult_start_o   = (state_q == S_START_M);
  assign div_start_o    = (state_q == S_START_D);
  assign hi_wr_o        = (state_q == S_COMMIT);
  assign lo_wr_o        = (state_q == S_COMMIT);
  assign done_o         = (state_q == S_COMMIT);
  assign div_zero_exc_o = (state_q == S_ERR) &  zcause_q;
  assign timeout_exc_o  = (state_q == S_ERR) & ~zcause_q;
  assign hilo_src_o     = src_q;
  assign busy_o         = (state_q != S_IDLE);

  assign w_any_req = req_mult_i | req_div_i | req_mfhi_i | req_mflo_i;
  assign stall_o   = (busy_o & w_any_req) |
                     ((state_q == S_IDLE) & req_mult_i & req_div_i);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_controller.sv
// ============================================================================
// tb_muldiv_controller : scoreboard bench for the mult/div sequencer
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_muldiv_controller;

  localparam int K_COMMIT = 0;
  localparam int K_DZ     = 1;
  localparam int K_TO     = 2;

  logic clk_i = 1'b0;
  logic reset_i, req_mult_i, req_div_i, req_mfhi_i, req_mflo_i;
  logic mult_ready_i, div_ready_i, div_zero_i;
  logic mult_start_o, div_start_o, hi_wr_o, lo_wr_o, hilo_src_o;
  logic busy_o, stall_o, done_o, div_zero_exc_o, timeout_exc_o;
  logic [9:0] outs;

  typedef struct {
    int          kind;
    logic        src;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_pop;
  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  int          kind_seen;
  logic [31:0] a_v = 0, b_v = 1;
  logic [31:0] hi_m = 0, lo_m = 0;
  logic [31:0] w_hi, w_lo;
  logic [63:0] prod;

  always #5 clk_i = ~clk_i;

  muldiv_controller #(.TIMEOUT_CYCLES(4), .CNT_W(6)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_mult_i(req_mult_i), .req_div_i(req_div_i),
    .req_mfhi_i(req_mfhi_i), .req_mflo_i(req_mflo_i),
    .mult_ready_i(mult_ready_i), .div_ready_i(div_ready_i), .div_zero_i(div_zero_i),
    .mult_start_o(mult_start_o), .div_start_o(div_start_o),
    .hi_wr_o(hi_wr_o), .lo_wr_o(lo_wr_o), .hilo_src_o(hilo_src_o),
    .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
    .div_zero_exc_o(div_zero_exc_o), .timeout_exc_o(timeout_exc_o)
  );

  assign outs = {mult_start_o, div_start_o, hi_wr_o, lo_wr_o, hilo_src_o,
                 busy_o, stall_o, done_o, div_zero_exc_o, timeout_exc_o};

  // Datapath stand-in: HI/LO registers fed by the mux the controller selects.
  always @(negedge clk_i) begin
    prod = {32'd0, a_v} * {32'd0, b_v};
    w_hi = hilo_src_o ? ((b_v == 0) ? 32'd0 : a_v % b_v) : prod[63:32];
    w_lo = hilo_src_o ? ((b_v == 0) ? 32'd0 : a_v / b_v) : prod[31:0];
    if (hi_wr_o | lo_wr_o | done_o) begin
      total++;
      if (!(hi_wr_o && lo_wr_o && done_o)) begin
        bad++;
        $display("FAIL commit_group: hi_wr=%b lo_wr=%b done=%b want all 1", hi_wr_o, lo_wr_o, done_o);
      end
    end
    if (done_o | div_zero_exc_o | timeout_exc_o) begin
      total++;
      kind_seen = done_o ? K_COMMIT : (div_zero_exc_o ? K_DZ : K_TO);
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got event kind %0d want none", kind_seen);
      end else begin
        e_pop = sb.pop_front();
        if (kind_seen !== e_pop.kind || (div_zero_exc_o && timeout_exc_o)) begin
          bad++;
          $display("FAIL sb_kind: got %0d (dz=%b to=%b) want %0d", kind_seen,
                   div_zero_exc_o, timeout_exc_o, e_pop.kind);
        end else if (done_o) begin
          total++;
          if ({hilo_src_o, w_hi, w_lo} !== {e_pop.src, e_pop.hi, e_pop.lo}) begin
            bad++;
            $display("FAIL sb_result: got src=%b hi=%h lo=%h want src=%b hi=%h lo=%h",
                     hilo_src_o, w_hi, w_lo, e_pop.src, e_pop.hi, e_pop.lo);
          end
        end
      end
    end
    if (hi_wr_o) begin
      wr_cnt++;
      hi_m = w_hi;
      lo_m = w_lo;
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  task automatic push_exp(input int kind, input logic src);
    exp_t        e;
    logic [63:0] p;
    p      = {32'd0, a_v} * {32'd0, b_v};
    e.kind = kind;
    e.src  = src;
    e.hi   = src ? a_v % b_v : p[63:32];
    e.lo   = src ? a_v / b_v : p[31:0];
    if (kind != K_COMMIT) begin
      e.hi = 0;
      e.lo = 0;
    end
    sb.push_back(e);
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (outs !== 10'b0) begin
      bad++;
      $display("FAIL reset_outs: got %b want %b", outs, 10'b0);
    end
  endtask

  task automatic test_mult;
    logic [9:0] ev [1:6];
    int         w0;
    ev = '{10'b1000010000, 10'b0000010000, 10'b0000010000, 10'b0000010000,
           10'b0011010100, 10'b0000000000};
    a_v = 32'h0001_2345; b_v = 32'h0010_0007;
    w0  = wr_cnt;
    req_mult_i = 1'b1;
    push_exp(K_COMMIT, 1'b0);
    #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL mult_idle_stall: got %b want 0", stall_o); end
    tick();
    req_mult_i = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      mult_ready_i = (i == 4);
      #1;
      total++;
      if (outs !== ev[i]) begin bad++; $display("FAIL mult_seq[%0d]: got %b want %b", i, outs, ev[i]); end
      if (i < 6) tick();
    end
    mult_ready_i = 1'b0;
    total++;
    if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL mult_writes: got %0d want 1", wr_cnt - w0); end
  endtask

  task automatic test_div_zero;
    logic [9:0]  ev [1:5];
    logic [31:0] hi0, lo0;
    int          w0;
    ev = '{10'b0100110000, 10'b0000110000, 10'b0000110000, 10'b0000110010, 10'b0000100000};
    hi0 = hi_m; lo0 = lo_m; w0 = wr_cnt;
    a_v = 32'd7; b_v = 32'd0;
    req_div_i = 1'b1;
    push_exp(K_DZ, 1'b1);
    tick();
    req_div_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      div_zero_i  = (i == 3);
      div_ready_i = (i == 3);
      #1;
      total++;
      if (outs !== ev[i]) begin bad++; $display("FAIL divzero_seq[%0d]: got %b want %b", i, outs, ev[i]); end
      if (i < 5) tick();
    end
    div_zero_i = 1'b0; div_ready_i = 1'b0;
    total++;
    if ({hi_m, lo_m} !== {hi0, lo0} || wr_cnt !== w0) begin
      bad++;
      $display("FAIL divzero_hilo: got hi=%h lo=%h writes=%0d want hi=%h lo=%h writes=%0d",
               hi_m, lo_m, wr_cnt, hi0, lo0, w0);
    end
  endtask

  task automatic test_hazard;
    logic [9:0] ev [1:5];
    ev = '{10'b0100111000, 10'b0000111000, 10'b0000111000, 10'b0011111100, 10'b0000100000};
    a_v = 32'd100; b_v = 32'd7;
    req_div_i = 1'b1; req_mfhi_i = 1'b1;
    push_exp(K_COMMIT, 1'b1);
    #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL hazard_idle_stall: got %b want 0", stall_o); end
    tick();
    req_div_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      div_ready_i = (i == 3);
      #1;
      total++;
      if (outs !== ev[i]) begin bad++; $display("FAIL hazard_seq[%0d]: got %b want %b", i, outs, ev[i]); end
      if (i < 5) tick();
    end
    req_mfhi_i = 1'b0;
    total++;
    if (hi_m !== 32'd2) begin bad++; $display("FAIL hazard_hi: got %0d want 2", hi_m); end
  endtask

  task automatic test_simul;
    logic [9:0] evm [1:3];
    logic [9:0] evd [1:4];
    evm = '{10'b1000011000, 10'b0000011000, 10'b0011011100};
    evd = '{10'b0100110000, 10'b0000110000, 10'b0011110100, 10'b0000100000};
    a_v = 32'd6; b_v = 32'd9;
    req_mult_i = 1'b1; req_div_i = 1'b1;
    push_exp(K_COMMIT, 1'b0);
    #1;
    total++;
    if (stall_o !== 1'b1) begin bad++; $display("FAIL simul_stall: got %b want 1", stall_o); end
    tick();
    req_mult_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      mult_ready_i = (i == 2);
      #1;
      total++;
      if (outs !== evm[i]) begin bad++; $display("FAIL simul_mult[%0d]: got %b want %b", i, outs, evm[i]); end
      tick();
    end
    mult_ready_i = 1'b0;
    push_exp(K_COMMIT, 1'b1);
    #1;
    total++;
    if (outs !== 10'b0) begin bad++; $display("FAIL simul_redo_idle: got %b want %b", outs, 10'b0); end
    tick();
    req_div_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      div_ready_i = (i == 2);
      #1;
      total++;
      if (outs !== evd[i]) begin bad++; $display("FAIL simul_div[%0d]: got %b want %b", i, outs, evd[i]); end
      if (i < 4) tick();
    end
    div_ready_i = 1'b0;
  endtask

  task automatic test_timeout;
    logic [9:0] ev [1:7];
    int         w0;
    for (int r = 0; r < 2; r++) begin
      ev = '{10'b1000010000, 10'b0000010000, 10'b0000010000, 10'b0000010000,
             10'b0000010000, (r == 0) ? 10'b0000010001 : 10'b0011010100, 10'b0000000000};
      a_v = 32'd11; b_v = 32'd13;
      w0  = wr_cnt;
      req_mult_i = 1'b1;
      push_exp((r == 0) ? K_TO : K_COMMIT, 1'b0);
      tick();
      req_mult_i = 1'b0;
      for (int i = 1; i <= 7; i++) begin
        mult_ready_i = (r == 1) && (i == 5);
        #1;
        total++;
        if (outs !== ev[i]) begin bad++; $display("FAIL timeout_seq[r%0d,%0d]: got %b want %b", r, i, outs, ev[i]); end
        if (i < 7) tick();
      end
      mult_ready_i = 1'b0;
      total++;
      if (wr_cnt - w0 !== r) begin bad++; $display("FAIL timeout_writes[r%0d]: got %0d want %0d", r, wr_cnt - w0, r); end
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0]  ev [1:4];
    logic [31:0] hi0;
    int          w0;
    ev  = '{10'b1000010000, 10'b0000010000, 10'b0011010100, 10'b0000000000};
    hi0 = hi_m; w0 = wr_cnt;
    a_v = 32'd50; b_v = 32'd5;
    req_div_i = 1'b1;
    tick();
    req_div_i = 1'b0;
    tick();
    reset_i = 1'b0;
    #1;
    total++;
    if (outs !== 10'b0000110000) begin bad++; $display("FAIL rstmid_wait: got %b want %b", outs, 10'b0000110000); end
    tick();
    reset_i = 1'b1; div_ready_i = 1'b1;
    #1;
    total++;
    if (outs !== 10'b0) begin bad++; $display("FAIL rstmid_after: got %b want %b", outs, 10'b0); end
    tick();
    div_ready_i = 1'b0;
    #1;
    total++;
    if (outs !== 10'b0 || wr_cnt !== w0 || hi_m !== hi0) begin
      bad++;
      $display("FAIL rstmid_nowrite: got outs=%b writes=%0d want outs=0 writes=%0d", outs, wr_cnt, w0);
    end
    a_v = 32'd3; b_v = 32'd5;
    req_mult_i = 1'b1;
    push_exp(K_COMMIT, 1'b0);
    tick();
    req_mult_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      mult_ready_i = (i == 2);
      #1;
      total++;
      if (outs !== ev[i]) begin bad++; $display("FAIL rstmid_mult[%0d]: got %b want %b", i, outs, ev[i]); end
      if (i < 4) tick();
    end
    mult_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b0;
    {req_mult_i, req_div_i, req_mfhi_i, req_mflo_i} = 4'b0;
    {mult_ready_i, div_ready_i, div_zero_i} = 3'b0;
    tick();
    tick();
    test_reset();
    reset_i = 1'b1;
    tick();
    test_mult();
    test_div_zero();
    test_hazard();
    test_simul();
    test_timeout();
    test_reset_mid();
    tick();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
